// File: rtl/serial_op_engine.sv
// Beat-serial operand loader, opcode-driven accumulator and beat-serial result streamer.
// Optional macro SERIAL_OP_ENGINE_ACC_KEEP_EN keeps acc across runs instead of clearing it on start.
module serial_op_engine #(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic         op_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         done,
    output logic [1:0]   state_o
);

    localparam int BEATS = N / W;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if ((N % 2 != 0) || (N % W != 0) || (BEATS < 2) || ((BEATS & (BEATS - 1)) != 0)) begin : g_param_check
        $error("serial_op_engine: N must be even, a multiple of W, and N/W a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXEC   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            done_q, done_d;

    function automatic logic [N-1:0] apply_op(input logic [2:0] code, input logic [N-1:0] a,
                                              input logic [N-1:0] b, input logic [N-1:0] c);
        logic [N:0]   sum;
        logic [N-1:0] mn;
        logic [N-1:0] mx;
        logic [N-1:0] res;
        sum = {1'b0, a} + {1'b0, b};
        mn  = (a < b) ? a : b;
        mx  = (a < b) ? b : a;
        res = '0;
        case (code)
            3'd0: res = (a & b) | c;
            3'd1: res = (a ^ b) + c;
            3'd2: res = (mx - mn) ^ c;
            3'd3: res = {c[N-1:N/2], mn[N/2-1:0]};
            3'd4: res = mx + (c << 1);
            // Saturate to all-ones when the unsigned add overflows N bits.
            3'd5: res = (sum[N] ? {N{1'b1}} : sum[N-1:0]) & c;
            3'd6: res = ((a & b) + ((a ^ b) >> 1)) | c;
            3'd7: res = {a[N-2:0], a[N-1]} ^ b ^ c;
            default: res = c;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    // Abort is tested before any handshake so an aborted cycle never writes or advances.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    a_d     = '0;
                    b_d     = '0;
                    beat_d  = '0;
`ifndef SERIAL_OP_ENGINE_ACC_KEEP_EN
                    acc_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (in_valid) begin
                    a_d[int'(beat_q)*W +: W] = a_in;
                    b_d[int'(beat_q)*W +: W] = b_in;
                    if (beat_q == LAST_BEAT) begin
                        state_d = EXEC;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end
            end
            EXEC: begin
                if (abort) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (op_valid) begin
                    acc_d = apply_op(op_code, a_q, b_q, acc_q);
                    if (op_last) begin
                        state_d = UNLOAD;
                        beat_d  = '0;
                    end
                end
            end
            UNLOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign op_ready  = (state_q == EXEC);
    assign out_valid = (state_q == UNLOAD);
    assign out_data  = out_valid ? acc_q[int'(beat_q)*W +: W] : '0;
    assign out_last  = out_valid && (beat_q == LAST_BEAT);
    assign done      = done_q;
    assign state_o   = state_q;

endmodule
